stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, 5, number of pipeline stages sequenced (range 2..8).
REQ-002 Parameter DIV_W, 23, prescaler width in bits.
REQ-003 Parameter MEM_STAGE, 3, index of the skippable memory-access stage (0 < MEM_STAGE < NUM_STAGES-1).
REQ-004 Parameter CNT_W, 16, stall-counter width.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-007 run  input  1  sequencing enable; low freezes prescaler and stage index.
REQ-008 div_val  input  DIV_W  tick period minus one; 0 = tick every CLK cycle.
REQ-009 stall  input  NUM_STAGES  per-stage hold request (e.g. memory wait on fetch/mem stages, execute-unit busy on the execute stage).
REQ-010 skip_mem  input  1  high = current instruction has no memory access; MEM_STAGE is bypassed.
REQ-011 clear_stats  input  1  synchronous clear of stall_cnt.
REQ-012 stage_en  output  NUM_STAGES  one-hot, one-CLK-wide stage enable pulse.
REQ-013 stage_idx  output  $clog2(NUM_STAGES)  index of the stage currently pending.
REQ-014 instr_done  output  1  one-CLK pulse when the last stage fires.
REQ-015 stall_cnt  output  CNT_W  saturating count of stalled ticks.

Function
REQ-016 Prescaler counts 0..div_val with run high; a "tick cycle" is any cycle with run high and count >= div_val; the count then returns to 0.
REQ-017 If div_val is lowered below the current count, the next cycle with run high is a tick cycle (>= compare); no wrap-through of 2^DIV_W.
REQ-018 With run low, prescaler count is forced to 0 and no tick occurs; stage_idx holds.
REQ-019 All outputs are registered; responses to a tick cycle appear in the following cycle.
REQ-020 On a tick cycle with stall[stage_idx] high: stage_en = 0, stage_idx holds, stall_cnt increments by 1, saturating at 2^CNT_W-1.
REQ-021 On a tick cycle with stall[stage_idx] low: stage_en[stage_idx] pulses for exactly one cycle and stage_idx advances.
REQ-022 Advance rule: next = stage_idx+1; if next == MEM_STAGE and skip_mem is high on that tick cycle, next = MEM_STAGE+1 and stage_en[MEM_STAGE] never pulses.
REQ-023 From stage NUM_STAGES-1 the index wraps to 0 and instr_done pulses in the same cycle as stage_en[NUM_STAGES-1].
REQ-024 stage_idx never takes a value >= NUM_STAGES; no idle or dead index states exist.
REQ-025 stall bits other than stall[stage_idx] are ignored.
REQ-026 stage_en is all-zero on every non-tick cycle; at most one bit is ever high.
REQ-027 clear_stats sets stall_cnt to 0; if it coincides with a stalled tick, clear wins (result 0).
REQ-028 div_val = 0 with no stalls yields one stage_en pulse every CLK cycle.

Reset
REQ-029 RST_N low asynchronously forces prescaler = 0, stage_idx = 0, stage_en = 0, instr_done = 0, stall_cnt = 0.
REQ-030 Reset mid-instruction discards progress; after release the first non-stalled tick fires stage 0 and the first tick occurs div_val+1 run-high cycles after release.

Structure
REQ-031 A shared package stage_seq_pkg holds stage-index constants (STG_FT=0, STG_DC=1, STG_EX=2, STG_MA=3, STG_WB=4) and the default parameter values.
REQ-032 The prescaler is a sub-module tick_div (inputs CLK, RST_N, run, div_val; output tick); stage and stall logic stay in stage_sequencer.

Verification
REQ-033 div_val=2, run=1, no stall, skip_mem=0 -> stage_en 1,2,4,8,16 on every 3rd cycle; instr_done with 16; stage_idx back to 0.
REQ-034 div_val=0, stall[2] high for 4 ticks -> stage_en pattern 1,2,(0 x4),4,8,16; stall_cnt=4.
REQ-035 div_val=0, skip_mem=1 on the EX tick -> stage_en 1,2,4,16; bit 3 never set; instr_done with 16.
REQ-036 div_val=10, count at 7, div_val changed to 3 -> tick on next cycle, then every 4 cycles.
REQ-037 CNT_W=4, stall held 20 ticks -> stall_cnt saturates at 15; clear_stats during stalled tick -> 0.
REQ-038 RST_N pulsed low mid-stage 3 (asynchronously, between edges) -> all outputs 0 immediately; after release first pulse is stage_en=1.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// Shared constants for the stage sequencer: stage indices and default parameters.
package stage_seq_pkg;

   // Stage indices of the classic five-stage pipeline
   localparam int unsigned STG_FT = 0;
   localparam int unsigned STG_DC = 1;
   localparam int unsigned STG_EX = 2;
   localparam int unsigned STG_MA = 3;
   localparam int unsigned STG_WB = 4;

   // Default parameter values
   localparam int unsigned NUM_STAGES_DEF = 5;
   localparam int unsigned DIV_W_DEF      = 23;
   localparam int unsigned MEM_STAGE_DEF  = STG_MA;
   localparam int unsigned CNT_W_DEF      = 16;

endpackage : stage_seq_pkg

// File: rtl/tick_div.sv
// Prescaler: produces a tick on every run-high cycle whose count has reached div_val.
//   CLK      - clock
//   RST_N    - async active-low reset
//   run      - count enable; low forces the count to 0 and suppresses tick
//   div_val  - tick period minus one
//   tick     - combinational tick-cycle indicator, consumed by registered logic
module tick_div
   import stage_seq_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             run,
   input  logic [DIV_W-1:0] div_val,
   output logic             tick
);

   logic [DIV_W-1:0] count_q;
   logic [DIV_W-1:0] count_d;

   // Greater-or-equal compare so a lowered div_val ticks at once instead of wrapping
   always_comb begin
      tick    = run && (count_q >= div_val);
      count_d = count_q;
      if (!run || tick) begin
         count_d = '0;
      end else begin
         count_d = count_q + DIV_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : tick_div

// File: rtl/stage_sequencer.sv
// Pipeline stage sequencer: walks a one-hot stage enable through NUM_STAGES stages
// at the prescaled tick rate, holding on per-stage stalls and optionally bypassing
// the memory-access stage.
//   CLK, RST_N   - clock, async active-low reset
//   run          - enable; low freezes prescaler and stage index
//   div_val      - tick period minus one
//   stall        - per-stage hold request (only the pending stage's bit matters)
//   skip_mem     - bypass MEM_STAGE when advancing into it
//   clear_stats  - synchronous clear of stall_cnt (wins over increment)
//   stage_en     - registered one-hot, one-cycle stage enable pulse
//   stage_idx    - registered index of the pending stage
//   instr_done   - registered pulse alongside the last stage's enable
//   stall_cnt    - registered saturating count of stalled ticks
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
   parameter int unsigned DIV_W      = DIV_W_DEF,
   parameter int unsigned MEM_STAGE  = MEM_STAGE_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          run,
   input  logic [DIV_W-1:0]              div_val,
   input  logic [NUM_STAGES-1:0]         stall,
   input  logic                          skip_mem,
   input  logic                          clear_stats,
   output logic [NUM_STAGES-1:0]         stage_en,
   output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
   output logic                          instr_done,
   output logic [CNT_W-1:0]              stall_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_STAGES);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);
   localparam logic [IDX_W-1:0] MEM_IDX      = IDX_W'(MEM_STAGE);
   localparam logic [IDX_W-1:0] POST_MEM_IDX = IDX_W'(MEM_STAGE + 1);

   logic                  tick;
   logic [IDX_W-1:0]      advance_idx;

   logic [IDX_W-1:0]      stage_idx_q,  stage_idx_d;
   logic [NUM_STAGES-1:0] stage_en_q,   stage_en_d;
   logic                  instr_done_q, instr_done_d;
   logic [CNT_W-1:0]      stall_cnt_q,  stall_cnt_d;

   tick_div #(
      .DIV_W (DIV_W)
   ) u_tick_div (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .run     (run),
      .div_val (div_val),
      .tick    (tick)
   );

   // Stage advance, stall hold and stall statistics
   always_comb begin
      stage_idx_d  = stage_idx_q;
      stage_en_d   = '0;
      instr_done_d = 1'b0;
      stall_cnt_d  = stall_cnt_q;
      // Only meaningful below LAST_IDX; the last stage takes the wrap branch
      advance_idx  = stage_idx_q + IDX_W'(1);

      if (tick) begin
         if (stall[stage_idx_q]) begin
            if (stall_cnt_q != '1) begin
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
         end else begin
            stage_en_d = NUM_STAGES'(1) << stage_idx_q;
            if (stage_idx_q == LAST_IDX) begin
               stage_idx_d  = '0;
               instr_done_d = 1'b1;
            end else if ((advance_idx == MEM_IDX) && skip_mem) begin
               stage_idx_d = POST_MEM_IDX;
            end else begin
               stage_idx_d = advance_idx;
            end
         end
      end

      if (clear_stats) begin
         stall_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stage_idx_q  <= '0;
         stage_en_q   <= '0;
         instr_done_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         stage_idx_q  <= stage_idx_d;
         stage_en_q   <= stage_en_d;
         instr_done_q <= instr_done_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign stage_en   = stage_en_q;
   assign stage_idx  = stage_idx_q;
   assign instr_done = instr_done_q;
   assign stall_cnt  = stall_cnt_q;

endmodule : stage_sequencer

// File: tb/tb_stage_sequencer.sv
// Directed testbench for stage_sequencer: default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation case.
module tb_stage_sequencer;

   localparam int unsigned NS    = 5;
   localparam int unsigned DW    = 23;
   localparam int unsigned CW    = 16;
   localparam int unsigned CW_S  = 4;

   logic          CLK;
   logic          RST_N;
   logic          run;
   logic [DW-1:0] div_val;
   logic [NS-1:0] stall;
   logic          skip_mem;
   logic          clear_stats;

   logic [NS-1:0] stage_en;
   logic [2:0]    stage_idx;
   logic          instr_done;
   logic [CW-1:0] stall_cnt;

   logic [NS-1:0]   s_stage_en;
   logic [2:0]      s_stage_idx;
   logic            s_instr_done;
   logic [CW_S-1:0] s_stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   stage_sequencer dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .run         (run),
      .div_val     (div_val),
      .stall       (stall),
      .skip_mem    (skip_mem),
      .clear_stats (clear_stats),
      .stage_en    (stage_en),
      .stage_idx   (stage_idx),
      .instr_done  (instr_done),
      .stall_cnt   (stall_cnt)
   );

   stage_sequencer #(.CNT_W(CW_S)) dut_sat (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .run         (run),
      .div_val     (div_val),
      .stall       (stall),
      .skip_mem    (skip_mem),
      .clear_stats (clear_stats),
      .stage_en    (s_stage_en),
      .stage_idx   (s_stage_idx),
      .instr_done  (s_instr_done),
      .stall_cnt   (s_stall_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Stall case: stall[2] held over four ticks at stage 2; on the release tick
   // every other bit is set to show it is ignored.
   logic [NS-1:0] t2_stall [9] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100,
                                   5'b00100, 5'b11011, 5'b00000, 5'b00000};
   logic [NS-1:0] t2_en    [9] = '{5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd8, 5'd16};

   logic [NS-1:0] t3_en    [4] = '{5'd1, 5'd2, 5'd4, 5'd16};
   logic [2:0]    t3_idx   [4] = '{3'd1, 3'd2, 3'd4, 3'd0};

   initial begin
      int exp_en;
      int exp_idx;

      RST_N       = 1'b0;
      run         = 1'b0;
      div_val     = '0;
      stall       = '0;
      skip_mem    = 1'b0;
      clear_stats = 1'b0;

      // Reset state
      #3;
      check_eq("rst_en",   32'(stage_en),   32'd0);
      check_eq("rst_idx",  32'(stage_idx),  32'd0);
      check_eq("rst_done", 32'(instr_done), 32'd0);
      check_eq("rst_cnt",  32'(stall_cnt),  32'd0);

      #14;
      RST_N   = 1'b1;
      run     = 1'b1;
      div_val = DW'(2);

      // div_val=2: one stage every third cycle, full instruction in 15 cycles
      for (int k = 1; k <= 15; k++) begin
         step();
         exp_en  = (k % 3 == 0) ? (1 << (k / 3 - 1)) : 0;
         exp_idx = (k / 3) % 5;
         check_eq("t1_en",   32'(stage_en),   32'(exp_en));
         check_eq("t1_idx",  32'(stage_idx),  32'(exp_idx));
         check_eq("t1_done", 32'(instr_done), (k == 15) ? 32'd1 : 32'd0);
      end

      // Frozen while run low; clear_stats applies
      run         = 1'b0;
      clear_stats = 1'b1;
      step();
      check_eq("frz_en",  32'(stage_en),  32'd0);
      check_eq("frz_idx", 32'(stage_idx), 32'd0);
      check_eq("clr_cnt", 32'(stall_cnt), 32'd0);
      clear_stats = 1'b0;
      run         = 1'b1;
      div_val     = '0;

      // Stall on execute stage for four ticks
      for (int k = 0; k < 9; k++) begin
         stall = t2_stall[k];
         step();
         check_eq("t2_en",   32'(stage_en),   32'(t2_en[k]));
         check_eq("t2_done", 32'(instr_done), (k == 8) ? 32'd1 : 32'd0);
      end
      check_eq("t2_cnt",     32'(stall_cnt),   32'd4);
      check_eq("t2_cnt_sat", 32'(s_stall_cnt), 32'd4);
      check_eq("t2_idx",     32'(stage_idx),   32'd0);

      // Memory stage bypass
      skip_mem = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("t3_en",   32'(stage_en),   32'(t3_en[k]));
         check_eq("t3_idx",  32'(stage_idx),  32'(t3_idx[k]));
         check_eq("t3_done", 32'(instr_done), (k == 3) ? 32'd1 : 32'd0);
      end
      skip_mem = 1'b0;

      // div_val lowered below the running count: immediate tick, then every 4 cycles
      div_val = DW'(10);
      for (int k = 1; k <= 16; k++) begin
         if (k == 8) div_val = DW'(3);
         step();
         exp_en = (k == 8) ? 1 : (k == 12) ? 2 : (k == 16) ? 4 : 0;
         check_eq("t4_en", 32'(stage_en), 32'(exp_en));
      end
      check_eq("t4_idx", 32'(stage_idx), 32'd3);
      check_eq("t4_cnt", 32'(stall_cnt), 32'd4);

      // Asynchronous reset between edges while stage 3 is pending
      #2;
      RST_N = 1'b0;
      #1;
      check_eq("arst_en",   32'(stage_en),    32'd0);
      check_eq("arst_idx",  32'(stage_idx),   32'd0);
      check_eq("arst_done", 32'(instr_done),  32'd0);
      check_eq("arst_cnt",  32'(stall_cnt),   32'd0);
      check_eq("arst_scnt", 32'(s_stall_cnt), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check_eq("t5_en", 32'(stage_en), (k == 4) ? 32'd1 : 32'd0);
      end
      check_eq("t5_idx", 32'(stage_idx), 32'd1);

      // Saturation: 20 stalled ticks on both instances
      div_val = '0;
      stall   = '1;
      for (int k = 1; k <= 20; k++) begin
         step();
         check_eq("t6_en",   32'(stage_en),    32'd0);
         check_eq("t6_cnt",  32'(stall_cnt),   32'(k));
         check_eq("t6_scnt", 32'(s_stall_cnt), (k > 15) ? 32'd15 : 32'(k));
      end
      check_eq("t6_idx", 32'(stage_idx), 32'd1);

      // clear_stats coinciding with a stalled tick wins
      clear_stats = 1'b1;
      step();
      check_eq("t6_clr_cnt",  32'(stall_cnt),   32'd0);
      check_eq("t6_clr_scnt", 32'(s_stall_cnt), 32'd0);
      clear_stats = 1'b0;
      step();
      check_eq("t6_re_cnt",  32'(stall_cnt),   32'd1);
      check_eq("t6_re_scnt", 32'(s_stall_cnt), 32'd1);

      // run low freezes everything, then resumes at the held stage
      stall = '0;
      run   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("t7_en",  32'(stage_en),  32'd0);
         check_eq("t7_idx", 32'(stage_idx), 32'd1);
      end
      run = 1'b1;
      step();
      check_eq("t7_resume_en",  32'(stage_en),  32'd2);
      check_eq("t7_resume_idx", 32'(stage_idx), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_stage_sequencer
